// File: rtl/piso_if.sv
// AXI4-Lite register-bus bundle for the PISO transmitter.
// Master drives requests and response-ready; slave drives request-ready and responses.
interface piso_if #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32
);
  logic                   aw_ready;
  logic                   aw_valid;
  logic [ADDR_BITS-1:0]   aw_addr;
  logic [2:0]             aw_prot;
  logic                   w_ready;
  logic                   w_valid;
  logic [DATA_BITS-1:0]   w_data;
  logic [DATA_BITS/8-1:0] w_strb;
  logic                   b_ready;
  logic                   b_valid;
  logic [1:0]             b_resp;
  logic                   ar_ready;
  logic                   ar_valid;
  logic [ADDR_BITS-1:0]   ar_addr;
  logic [2:0]             ar_prot;
  logic                   r_ready;
  logic                   r_valid;
  logic [DATA_BITS-1:0]   r_data;
  logic [1:0]             r_resp;

  modport master (
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp,
    output aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
           ar_valid, ar_addr, ar_prot, r_ready
  );

  modport slave (
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp,
    input  aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
           ar_valid, ar_addr, ar_prot, r_ready
  );
endinterface

// File: rtl/piso.sv
// PISO transmitter: AXI4-Lite pushes words into a FIFO; serializer streams them LSB-first on sout.
// First bit is visible 2 cycles after the write response rises; a full FIFO rejects writes with SLVERR.
module piso #(
  parameter int                        AXI4_ADDR_BITS = 32,
  parameter int                        AXI4_DATA_BITS = 32,
  parameter int                        PISO_WIDTH     = 32,
  parameter int                        PISO_DEPTH     = 16,
  parameter logic [AXI4_ADDR_BITS-1:0] MMIO_BASE_ADDR = 32'h0000_1000
) (
  input  logic  clk,
  input  logic  rst,
  piso_if.slave s_axi4lite,
  output logic  sout,
  output logic  sout_valid
);
  localparam int PTR_W = $clog2(PISO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(PISO_WIDTH);
  localparam logic [AXI4_ADDR_BITS-1:0] OFF_MASK = AXI4_ADDR_BITS'(15);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic                      aw_pend, w_pend, rd_pend;
  logic [AXI4_ADDR_BITS-1:0] aw_addr_q, ar_addr_q;
  logic [AXI4_DATA_BITS-1:0] w_data_q, rd_val;
  logic                      b_valid_q, r_valid_q;
  logic [1:0]                b_resp_q, r_resp_q;
  logic [AXI4_DATA_BITS-1:0] r_data_q;

  logic [PISO_WIDTH-1:0] mem [PISO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [LVL_W-1:0]      level;
  logic                  full, empty, enable;

  state_t                state;
  logic [PISO_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      cnt;

  logic wr_exec, wr_hit, rd_hit, push_req, push, pop, flush, ctrl_wr, busy;
  logic unused_ok;

  assign s_axi4lite.aw_ready = !aw_pend && !b_valid_q;
  assign s_axi4lite.w_ready  = !w_pend && !b_valid_q;
  assign s_axi4lite.ar_ready = !rd_pend && !r_valid_q;
  assign s_axi4lite.b_valid  = b_valid_q;
  assign s_axi4lite.b_resp   = b_resp_q;
  assign s_axi4lite.r_valid  = r_valid_q;
  assign s_axi4lite.r_data   = r_data_q;
  assign s_axi4lite.r_resp   = r_resp_q;
  assign unused_ok = ^{s_axi4lite.aw_prot, s_axi4lite.ar_prot, s_axi4lite.w_strb};

  assign full     = (level == LVL_W'(PISO_DEPTH));
  assign empty    = (level == '0);
  assign busy     = (state != IDLE);
  assign wr_exec  = aw_pend && w_pend;
  assign wr_hit   = (aw_addr_q & ~OFF_MASK) == MMIO_BASE_ADDR;
  assign rd_hit   = (ar_addr_q & ~OFF_MASK) == MMIO_BASE_ADDR;
  assign push_req = wr_exec && wr_hit && (aw_addr_q[3:0] == 4'h0);
  assign push     = push_req && !full;
  assign ctrl_wr  = wr_exec && wr_hit && (aw_addr_q[3:0] == 4'hC);
  assign flush    = ctrl_wr && w_data_q[1];
  // Pop on entry from IDLE and on the last bit of a word, so words stream back-to-back.
  assign pop      = !flush && enable && !empty &&
                    ((state == IDLE) || (cnt == CNT_W'(PISO_WIDTH - 1)));

  always_comb begin
    rd_val = '0;
    if (rd_hit) begin
      case (ar_addr_q[3:0])
        4'h4:    rd_val = AXI4_DATA_BITS'(level);
        4'h8:    rd_val = AXI4_DATA_BITS'({busy, enable, full, !empty});
        4'hC:    rd_val = AXI4_DATA_BITS'(enable);
        default: rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_pend   <= 1'b0;
      w_pend    <= 1'b0;
      rd_pend   <= 1'b0;
      aw_addr_q <= '0;
      ar_addr_q <= '0;
      w_data_q  <= '0;
      b_valid_q <= 1'b0;
      b_resp_q  <= 2'b00;
      r_valid_q <= 1'b0;
      r_resp_q  <= 2'b00;
      r_data_q  <= '0;
    end else begin
      if (s_axi4lite.aw_valid && s_axi4lite.aw_ready) begin
        aw_pend   <= 1'b1;
        aw_addr_q <= s_axi4lite.aw_addr;
      end
      if (s_axi4lite.w_valid && s_axi4lite.w_ready) begin
        w_pend   <= 1'b1;
        w_data_q <= s_axi4lite.w_data;
      end
      if (wr_exec) begin
        aw_pend   <= 1'b0;
        w_pend    <= 1'b0;
        b_valid_q <= 1'b1;
        b_resp_q  <= (push_req && full) ? 2'b10 : 2'b00;
      end else if (b_valid_q && s_axi4lite.b_ready) begin
        b_valid_q <= 1'b0;
      end
      if (s_axi4lite.ar_valid && s_axi4lite.ar_ready) begin
        rd_pend   <= 1'b1;
        ar_addr_q <= s_axi4lite.ar_addr;
      end
      if (rd_pend) begin
        rd_pend   <= 1'b0;
        r_valid_q <= 1'b1;
        r_data_q  <= rd_val;
        r_resp_q  <= 2'b00;
      end else if (r_valid_q && s_axi4lite.r_ready) begin
        r_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= w_data_q[PISO_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      enable <= 1'b1;
    end else begin
      if (ctrl_wr) enable <= w_data_q[0];
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        level <= level + LVL_W'(push) - LVL_W'(pop);
      end
    end
  end

  // sout/sout_valid are a registered copy of the shifter head, one cycle behind the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
    end else begin
      sout_valid <= (state == SHIFT);
      sout       <= (state == SHIFT) && shreg[0];
      if (flush) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (pop) begin
        shreg <= mem[rd_ptr];
        cnt   <= '0;
        state <= SHIFT;
      end else if (state == SHIFT) begin
        if (cnt == CNT_W'(PISO_WIDTH - 1)) begin
          state <= IDLE;
        end else begin
          shreg <= shreg >> 1;
          cnt   <= cnt + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_piso.sv
// Bench for piso: AXI4-Lite driver, a bit-level expected queue fed at push time,
// and an independent monitor that pops and compares every valid serial bit.
module tb_piso;
  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam logic [31:0] TXDATA = BASE + 32'h0;
  localparam logic [31:0] LEVEL  = BASE + 32'h4;
  localparam logic [31:0] STATUS = BASE + 32'h8;
  localparam logic [31:0] CTRL   = BASE + 32'hC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sout, sout_valid;

  piso_if #(.ADDR_BITS(32), .DATA_BITS(32)) bus ();

  piso #(
    .AXI4_ADDR_BITS(32), .AXI4_DATA_BITS(32), .PISO_WIDTH(32),
    .PISO_DEPTH(16), .MMIO_BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst(rst), .s_axi4lite(bus), .sout(sout), .sout_valid(sout_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  total_cnt = 0;
  int  pass_cnt  = 0;
  bit  exp_q[$];
  int  run_start[$];
  int  run_len[$];
  int  cur_run = 0;
  bit  prev_v  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] status_of(input bit busy, input bit en, input int lvl);
    return {28'b0, busy, en, lvl == 16, lvl != 0};
  endfunction

  task automatic push_bits(input logic [31:0] word);
    for (int i = 0; i < 32; i++) exp_q.push_back(((word >> i) & 32'd1) != 0);
  endtask

  // Monitor: every valid bit must match the head of the expected queue.
  initial begin : monitor
    bit eb;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (prev_v) run_len.push_back(cur_run);
        prev_v = 1'b0;
        cur_run = 0;
      end else begin
        if (sout_valid) begin
          if (!prev_v) begin
            run_start.push_back(cyc);
            cur_run = 0;
          end
          cur_run++;
          if (exp_q.size() == 0) chk("sout_unexpected_valid", sout_valid, 1'b0);
          else begin
            eb = exp_q.pop_front();
            chk("sout_bit", sout, eb);
          end
        end else begin
          if (prev_v) run_len.push_back(cur_run);
          chk("sout_zero_when_idle", sout, 1'b0);
        end
        prev_v = sout_valid;
      end
    end
  end

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           output logic [1:0] resp, output int bcyc);
    bit aw_done = 0, w_done = 0, hs_aw, hs_w;
    int n = 0;
    bus.aw_addr = addr; bus.w_data = data;
    bus.aw_valid = 1'b1; bus.w_valid = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      hs_aw = bus.aw_valid && bus.aw_ready;
      hs_w  = bus.w_valid && bus.w_ready;
      @(negedge clk); n++;
      if (hs_aw) begin bus.aw_valid = 1'b0; aw_done = 1; end
      if (hs_w)  begin bus.w_valid = 1'b0;  w_done = 1;  end
    end
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    n = 0;
    while (!bus.b_valid && n < 20) begin @(negedge clk); n++; end
    chk("b_valid_seen", bus.b_valid, 1'b1);
    resp = bus.b_resp;
    bcyc = cyc;
  endtask

  task automatic wr(input string name, input logic [31:0] addr, input logic [31:0] data,
                    input logic [1:0] exp_resp);
    logic [1:0] resp; int bc;
    axi_write(addr, data, resp, bc);
    chk(name, {30'b0, resp}, {30'b0, exp_resp});
  endtask

  task automatic axi_read(input logic [31:0] addr, input int hold,
                          output logic [31:0] data, output logic [1:0] resp);
    bit hs; int n = 0;
    bus.r_ready = (hold == 0);
    bus.ar_addr = addr; bus.ar_valid = 1'b1;
    while (bus.ar_valid && n < 20) begin
      hs = bus.ar_ready;
      @(negedge clk); n++;
      if (hs) bus.ar_valid = 1'b0;
    end
    bus.ar_valid = 1'b0;
    n = 0;
    while (!bus.r_valid && n < 20) begin @(negedge clk); n++; end
    chk("r_valid_seen", bus.r_valid, 1'b1);
    data = bus.r_data;
    resp = bus.r_resp;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("r_valid_hold", bus.r_valid, 1'b1);
      chk("r_data_hold", bus.r_data, data);
      chk("ar_ready_hold", bus.ar_ready, 1'b0);
    end
    if (hold > 0) begin
      bus.r_ready = 1'b1;
      @(negedge clk);
      chk("r_valid_release", bus.r_valid, 1'b0);
    end
    bus.r_ready = 1'b1;
  endtask

  task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d; logic [1:0] r;
    axi_read(addr, 0, d, r);
    chk(name, d, exp);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || sout_valid) && n < budget) begin @(negedge clk); n++; end
    chk("drain_in_time", n < budget, 1'b1);
    repeat (3) @(negedge clk);
    chk("drain_expected_empty", exp_q.size(), 0);
  endtask

  task automatic wait_run(input int bits);
    int n = 0;
    while (!(sout_valid && cur_run >= bits) && n < 200) begin @(negedge clk); n++; end
    chk("run_reached", n < 200, 1'b1);
  endtask

  task automatic clear_runs();
    run_start.delete();
    run_len.delete();
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] d, w;
    logic [1:0]  r;
    int          k;
    bus.aw_valid = 0; bus.aw_addr = 0; bus.aw_prot = 0;
    bus.w_valid = 0; bus.w_data = 0; bus.w_strb = 4'hF; bus.b_ready = 1;
    bus.ar_valid = 0; bus.ar_addr = 0; bus.ar_prot = 0; bus.r_ready = 1;

    repeat (3) @(negedge clk);
    chk("rst_sout", sout, 0);
    chk("rst_sout_valid", sout_valid, 0);
    chk("rst_b_valid", bus.b_valid, 0);
    chk("rst_r_valid", bus.r_valid, 0);
    chk("rst_b_resp", bus.b_resp, 0);
    chk("rst_r_resp", bus.r_resp, 0);
    chk("rst_r_data", bus.r_data, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_aw_ready", bus.aw_ready, 1);
    chk("rst_w_ready", bus.w_ready, 1);
    chk("rst_ar_ready", bus.ar_ready, 1);
    rd("rst_level", LEVEL, 0);
    rd("rst_status", STATUS, status_of(0, 1, 0));
    rd("rst_ctrl", CTRL, 1);

    // Single word: latency, length, bit pattern.
    clear_runs();
    push_bits(32'h0000_0005);
    axi_write(TXDATA, 32'h0000_0005, r, k);
    chk("w5_resp", r, 0);
    wait_drain(200);
    chk("w5_runs", run_start.size(), 1);
    if (run_start.size() > 0) chk("w5_latency", run_start[0] - k, 2);
    if (run_len.size() > 0) chk("w5_len", run_len[0], 32);
    rd("w5_status", STATUS, status_of(0, 1, 0));

    // Back-to-back words stream without a gap.
    clear_runs();
    push_bits(32'hFFFF_FFFF);
    wr("b2b_resp0", TXDATA, 32'hFFFF_FFFF, 2'b00);
    push_bits(32'h0);
    wr("b2b_resp1", TXDATA, 32'h0, 2'b00);
    wait_drain(300);
    chk("b2b_runs", run_len.size(), 1);
    if (run_len.size() > 0) chk("b2b_len", run_len[0], 64);

    // Disabled: decode misses, read hold, unmapped reads, flush without enable.
    wr("dis_ctrl", CTRL, 32'h0, 2'b00);
    for (int i = 0; i < 3; i++) wr("dis_push", TXDATA, $urandom, 2'b00);
    wr("miss_off10", BASE + 32'h10, 32'h1, 2'b00);
    wr("miss_base", BASE ^ 32'h100, 32'hDEAD, 2'b00);
    axi_read(LEVEL, 3, d, r);
    chk("hold_level", d, 3);
    axi_read(TXDATA, 0, d, r);
    chk("rd_txdata", d, 0);
    chk("rd_txdata_resp", r, 0);
    axi_read(BASE + 32'h10, 0, d, r);
    chk("rd_miss", d, 0);
    chk("rd_miss_resp", r, 0);
    rd("dis_ctrl_rd", CTRL, 0);
    rd("dis_status", STATUS, status_of(0, 0, 3));
    wr("dis_flush", CTRL, 32'h2, 2'b00);
    rd("dis_flush_level", LEVEL, 0);
    rd("dis_flush_ctrl", CTRL, 0);

    // Fill to full, overflow, then release.
    clear_runs();
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      push_bits(w);
      wr("fill_resp", TXDATA, w, 2'b00);
    end
    rd("full_level", LEVEL, 16);
    rd("full_status", STATUS, status_of(0, 0, 16));
    wr("overflow_resp", TXDATA, 32'h1234_5678, 2'b10);
    rd("overflow_level", LEVEL, 16);
    wr("enable", CTRL, 32'h1, 2'b00);
    wait_drain(700);
    chk("full_runs", run_len.size(), 1);
    if (run_len.size() > 0) chk("full_len", run_len[0], 512);
    rd("full_end_level", LEVEL, 0);

    // Flush mid-word.
    clear_runs();
    w = $urandom; push_bits(w); wr("fl_push0", TXDATA, w, 2'b00);
    w = $urandom; push_bits(w); wr("fl_push1", TXDATA, w, 2'b00);
    wait_run(8);
    wr("fl_ctrl", CTRL, 32'h3, 2'b00);
    @(negedge clk);
    chk("fl_valid_drop", sout_valid, 0);
    exp_q.delete();
    rd("fl_level", LEVEL, 0);
    rd("fl_status", STATUS, status_of(0, 1, 0));
    repeat (40) @(negedge clk);
    chk("fl_no_restart", run_start.size(), 1);

    // Asynchronous reset mid-word.
    push_bits(32'hFFFF_FFFF);
    wr("rst_push", TXDATA, 32'hFFFF_FFFF, 2'b00);
    wait_run(5);
    #2 rst = 1'b1;
    #1;
    chk("arst_sout_valid", sout_valid, 0);
    chk("arst_sout", sout, 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd("arst_level", LEVEL, 0);
    rd("arst_status", STATUS, status_of(0, 1, 0));

    // Random words with random gaps.
    for (int i = 0; i < 12; i++) begin
      w = $urandom;
      push_bits(w);
      wr("rnd_resp", TXDATA, w, 2'b00);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    wait_drain(800);
    rd("rnd_level", LEVEL, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
